// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: RAW hazard detection,
// MDU busy countdown, exception/eret flush sequencing and a stall-cycle counter.

module pipe_hazard_src (
   input  logic [4:0] src,
   input  logic [1:0] tuse,
   input  logic [4:0] wa_E,
   input  logic [1:0] tnew_E,
   input  logic [4:0] wa_M,
   input  logic [1:0] tnew_M,
   output logic       haz
);
   // $0 is hardwired; W stage results are always forwardable so it never stalls
   assign haz = (src != 5'd0) &&
                (((src == wa_E) && (tuse < tnew_E)) ||
                 ((src == wa_M) && (tuse < tnew_M)));
endmodule

module pipe_hazard_ctrl #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [1:0]  tuse_rs_D,
   input  logic [1:0]  tuse_rt_D,
   input  logic [4:0]  wa_E,
   input  logic [1:0]  tnew_E,
   input  logic [4:0]  wa_M,
   input  logic [1:0]  tnew_M,
   input  logic        md_use_D,
   input  logic        md_start_E,
   input  logic        md_div_E,
   input  logic        exc_req,
   input  logic        eret_M,
   output logic        WR_F,
   output logic        WR_D,
   output logic        clr_D,
   output logic        clr_E,
   output logic        clr_M,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] stall_cnt
);
   localparam int NUM_SRC = 2;

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   state_t state, state_nxt;
   logic [3:0]  md_cnt;
   logic [31:0] stall_cnt_q;
   logic        md_stall, stall, flush;

   logic [NUM_SRC-1:0][4:0] src;
   logic [NUM_SRC-1:0][1:0] tuse;
   logic [NUM_SRC-1:0]      haz;

   assign src  = {rt_D, rs_D};
   assign tuse = {tuse_rt_D, tuse_rs_D};

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      pipe_hazard_src u_haz (
         .src    (src[g]),
         .tuse   (tuse[g]),
         .wa_E   (wa_E),
         .tnew_E (tnew_E),
         .wa_M   (wa_M),
         .tnew_M (tnew_M),
         .haz    (haz[g])
      );
   end

   assign md_busy  = md_start_E || (md_cnt != 4'd0);
   assign md_done  = (md_cnt == 4'd1);
   assign md_stall = md_use_D && md_busy;
   assign stall    = (|haz) || md_stall;
   // a second exception while the stages are being cleared is not taken
   assign flush    = (exc_req || eret_M) && (state == RUN);
   assign stall_cnt = stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (flush) state_nxt = FLUSH;
         FLUSH:   state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      WR_F  = 1'b1;
      WR_D  = 1'b1;
      clr_D = 1'b0;
      clr_E = 1'b0;
      clr_M = 1'b0;
      if (flush) begin
         WR_D  = 1'b0;
         clr_D = 1'b1;
         clr_E = 1'b1;
         clr_M = 1'b1;
      end else if (stall) begin
         WR_F  = 1'b0;
         WR_D  = 1'b0;
         clr_E = 1'b1;
      end
   end

   // a start that coincides with a flush is squashed along with its instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         md_cnt <= 4'd0;
      else if (md_start_E && !flush)
         md_cnt <= md_div_E ? 4'(DIV_LAT) : 4'(MULT_LAT);
      else if (md_cnt != 4'd0)
         md_cnt <= md_cnt - 4'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt_q <= 32'd0;
      else if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, MDU windows, flush, saturation, async reset.

module tb_pipe_hazard_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs_D, rt_D, wa_E, wa_M;
   logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
   logic        md_use_D, md_start_E, md_div_E, exc_req, eret_M;
   logic        WR_F, WR_D, clr_D, clr_E, clr_M, md_busy, md_done;
   logic [31:0] stall_cnt;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_sc = 32'd0;

   localparam logic [4:0] C_RUN   = 5'b11000;
   localparam logic [4:0] C_STALL = 5'b00010;
   localparam logic [4:0] C_FLUSH = 5'b10111;

   pipe_hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .reset(reset),
      .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
      .wa_E(wa_E), .tnew_E(tnew_E), .wa_M(wa_M), .tnew_M(tnew_M),
      .md_use_D(md_use_D), .md_start_E(md_start_E), .md_div_E(md_div_E),
      .exc_req(exc_req), .eret_M(eret_M),
      .WR_F(WR_F), .WR_D(WR_D), .clr_D(clr_D), .clr_E(clr_E), .clr_M(clr_M),
      .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] ctrl();
      return {WR_F, WR_D, clr_D, clr_E, clr_M};
   endfunction

   task automatic idle();
      rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
      wa_E = 5'd0; tnew_E = 2'd0; wa_M = 5'd0; tnew_M = 2'd0;
      md_use_D = 1'b0; md_start_E = 1'b0; md_div_E = 1'b0;
      exc_req = 1'b0; eret_M = 1'b0;
   endtask

   // inputs change at negedge, outputs sampled 1 time unit later
   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      #12;
      total++;
      if ({ctrl(), md_busy, md_done} !== 7'b1100000) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=%b", {ctrl(), md_busy, md_done}, 7'b1100000);
      end
      total++;
      if (stall_cnt !== 32'd0) begin
         bad++; $display("FAIL reset_stall_cnt got=%h exp=0", stall_cnt);
      end
      step(); reset = 1'b0;
      exp_sc = 32'd0;
   endtask

   task automatic test_hazard();
      // load-use on rs through E
      step(); idle(); wa_E = 5'd5; tnew_E = 2'd2; rs_D = 5'd5; tuse_rs_D = 2'd1; #1;
      total++;
      if (ctrl() !== C_STALL) begin bad++; $display("FAIL load_use got=%b exp=%b", ctrl(), C_STALL); end
      exp_sc++;
      // same with rs=$0: no hazard; check count advanced once
      step(); rs_D = 5'd0; #1;
      total++;
      if (ctrl() !== C_RUN) begin bad++; $display("FAIL rs_zero got=%b exp=%b", ctrl(), C_RUN); end
      total++;
      if (stall_cnt !== exp_sc) begin bad++; $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, exp_sc); end
      // tuse == tnew: forwardable in time, no stall
      step(); rs_D = 5'd5; tuse_rs_D = 2'd2; #1;
      total++;
      if (ctrl() !== C_RUN) begin bad++; $display("FAIL tuse_eq_tnew got=%b exp=%b", ctrl(), C_RUN); end
      // rt through M
      step(); idle(); wa_M = 5'd9; tnew_M = 2'd1; rt_D = 5'd9; tuse_rt_D = 2'd0; #1;
      total++;
      if (ctrl() !== C_STALL) begin bad++; $display("FAIL rt_via_M got=%b exp=%b", ctrl(), C_STALL); end
      exp_sc++;
      // tuse=3 (unused) never stalls
      step(); tuse_rt_D = 2'd3; wa_E = 5'd9; tnew_E = 2'd2; #1;
      total++;
      if (ctrl() !== C_RUN) begin bad++; $display("FAIL tuse_unused got=%b exp=%b", ctrl(), C_RUN); end
      total++;
      if (stall_cnt !== exp_sc) begin bad++; $display("FAIL hazard_cnt got=%0d exp=%0d", stall_cnt, exp_sc); end
   endtask

   task automatic test_mult();
      int errs = 0;
      for (int i = 0; i <= 6; i++) begin
         step(); idle(); md_use_D = 1'b1; md_start_E = (i == 0); #1;
         if (ctrl() !== ((i <= 5) ? C_STALL : C_RUN) || md_done !== (i == 5) || md_busy !== (i <= 5)) begin
            errs++;
            $display("FAIL mult_cycle%0d got ctrl=%b done=%b busy=%b", i, ctrl(), md_done, md_busy);
         end
      end
      total++;
      if (errs != 0) bad++;
      exp_sc += 6;
      step(); idle(); #1;
      total++;
      if (stall_cnt !== exp_sc) begin bad++; $display("FAIL mult_cnt got=%0d exp=%0d", stall_cnt, exp_sc); end
   endtask

   task automatic test_div();
      int busy_n = 0, done_n = 0, done_at = -1;
      for (int i = 0; i <= 13; i++) begin
         step(); idle(); md_start_E = (i == 0); md_div_E = (i == 0); #1;
         if (md_busy === 1'b1) busy_n++;
         if (md_done === 1'b1) begin done_n++; done_at = i; end
      end
      total++;
      if (busy_n != 11) begin bad++; $display("FAIL div_busy_cycles got=%0d exp=11", busy_n); end
      total++;
      if (done_n != 1 || done_at != 10) begin
         bad++; $display("FAIL div_done got=%0d pulses at %0d exp=1 at 10", done_n, done_at);
      end
   endtask

   task automatic test_back_to_back();
      int done_at = -1;
      // reload while counting: the divide restarts the window
      for (int i = 0; i <= 14; i++) begin
         step(); idle();
         md_start_E = (i == 0) || (i == 2); md_div_E = (i == 2); #1;
         if (md_done === 1'b1 && done_at < 0) done_at = i;
      end
      total++;
      if (done_at != 12) begin bad++; $display("FAIL reload_done got=%0d exp=12", done_at); end
   endtask

   task automatic test_flush();
      step(); idle(); wa_E = 5'd5; tnew_E = 2'd2; rs_D = 5'd5; tuse_rs_D = 2'd1; exc_req = 1'b1; #1;
      total++;
      if (ctrl() !== C_FLUSH) begin bad++; $display("FAIL exc_over_stall got=%b exp=%b", ctrl(), C_FLUSH); end
      step(); #1;   // exc_req still held, now in FLUSH
      total++;
      if (ctrl() !== C_STALL) begin bad++; $display("FAIL exc_held got=%b exp=%b", ctrl(), C_STALL); end
      total++;
      if (stall_cnt !== exp_sc) begin bad++; $display("FAIL flush_cnt got=%0d exp=%0d", stall_cnt, exp_sc); end
      exp_sc++;
      step(); idle(); eret_M = 1'b1; #1;
      total++;
      if (ctrl() !== C_FLUSH) begin bad++; $display("FAIL eret got=%b exp=%b", ctrl(), C_FLUSH); end
      total++;
      if (stall_cnt !== exp_sc) begin bad++; $display("FAIL flush_state_cnt got=%0d exp=%0d", stall_cnt, exp_sc); end
      step(); idle(); #1;
   endtask

   task automatic test_exc_md();
      int errs = 0;
      step(); idle(); exc_req = 1'b1; md_start_E = 1'b1; md_div_E = 1'b1; #1;
      total++;
      if (ctrl() !== C_FLUSH) begin bad++; $display("FAIL exc_md_flush got=%b exp=%b", ctrl(), C_FLUSH); end
      for (int i = 1; i <= 12; i++) begin
         step(); idle(); #1;
         if (md_busy !== 1'b0 || md_done !== 1'b0) begin
            errs++; $display("FAIL exc_md_cycle%0d busy=%b done=%b exp 0 0", i, md_busy, md_done);
         end
      end
      total++;
      if (errs != 0) bad++;
   endtask

   task automatic test_sat_reset();
      step(); idle();
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1 release dut.stall_cnt_q;
      wa_E = 5'd5; tnew_E = 2'd2; rs_D = 5'd5; tuse_rs_D = 2'd1;
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         total++;
         if (stall_cnt !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL sat_cycle%0d got=%h exp=ffffffff", i, stall_cnt);
         end
      end
      step(); idle(); md_start_E = 1'b1; md_div_E = 1'b1;
      for (int i = 0; i < 4; i++) begin step(); idle(); end
      #2 reset = 1'b1;
      #1;
      total++;
      if (md_busy !== 1'b0 || md_done !== 1'b0) begin
         bad++; $display("FAIL async_reset_md busy=%b done=%b exp 0 0", md_busy, md_done);
      end
      total++;
      if (stall_cnt !== 32'd0) begin bad++; $display("FAIL async_reset_cnt got=%h exp=0", stall_cnt); end
      step(); reset = 1'b0;
      begin
         int done_n = 0;
         for (int i = 0; i < 10; i++) begin step(); #1; if (md_done === 1'b1) done_n++; end
         total++;
         if (done_n != 0) begin bad++; $display("FAIL reset_done_pulses got=%0d exp=0", done_n); end
      end
   endtask

   initial begin
      test_reset();
      test_hazard();
      test_mult();
      test_div();
      test_back_to_back();
      test_flush();
      test_exc_md();
      test_sat_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
